// File: rtl/uart_tx_frame_pkg.sv
// Shared definitions for the UART transmit frame: FSM state encoding,
// line idle level, parity type codes and a bit-index width helper.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  // Width of an index that must hold 0..dw-1 (at least one bit).
  function automatic int idx_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte handshake, frame configuration and serial outputs of the UART
// transmitter. The master side supplies bytes; the slave side serialises.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
);
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic                      TX_OUT;
  logic                      Busy;

  modport master (
    output Prescale, P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  Prescale, P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Bit timer: counts clock edges 1..Ps inside each bit and pulses o_bit_done
// on the last edge; also tracks the data bit index while i_adv is high.
module uart_tx_bit_timer
  import uart_tx_frame_pkg::*;
#(
  parameter  int DATA_WIDTH     = 8,
  parameter  int PRESCALE_WIDTH = 5,
  localparam int IDX_W          = idx_width(DATA_WIDTH)
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      i_en,
  input  logic                      i_adv,
  input  logic [PRESCALE_WIDTH-1:0] i_ps,
  output logic                      o_bit_done,
  output logic [IDX_W-1:0]          o_bit_idx
);

  logic [PRESCALE_WIDTH-1:0] r_edge;
  logic [IDX_W-1:0]          r_idx;
  logic                      w_done;

  assign w_done     = i_en && (r_edge == i_ps);
  assign o_bit_done = w_done;
  assign o_bit_idx  = r_idx;

  // Edge counter and bit index; both return to their start values when disabled.
  always_ff @(posedge CLK or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!Reset) begin
      r_edge <= PRESCALE_WIDTH'(1);
      r_idx  <= '0;
    end else if (!i_en) begin
      r_edge <= PRESCALE_WIDTH'(1);
      r_idx  <= '0;
    end else if (w_done) begin
      r_edge <= PRESCALE_WIDTH'(1);
      if (i_adv) begin
        r_idx <= (r_idx == IDX_W'(DATA_WIDTH - 1)) ? '0 : r_idx + 1'b1;
      end
    end else begin
      r_edge <= r_edge + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts one byte per Data_Valid while idle and sends
// start, data LSB-first, optional parity and stop, each held Ps cycles.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input logic             CLK,
  input logic             Reset,
  uart_tx_frame_if.slave  bus
);

  localparam int IDX_W = idx_width(DATA_WIDTH);

  state_e                    r_state;
  state_e                    w_next;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic [PRESCALE_WIDTH-1:0] r_ps;
  logic                      r_tx;
  logic                      r_busy;

  logic                      w_accept;
  logic                      w_bit_done;
  logic [IDX_W-1:0]          w_idx;
  logic [IDX_W-1:0]          w_out_idx;
  logic                      w_par;
  logic                      w_tx_d;
  logic                      w_busy_d;

  assign w_accept = (r_state == ST_IDLE) && bus.Data_Valid;
  assign w_par    = (^r_data) ^ (r_par_typ == PAR_ODD);

  uart_tx_bit_timer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_timer (
    .CLK        (CLK),
    .Reset      (Reset),
    .i_en       (r_state != ST_IDLE),
    .i_adv      (r_state == ST_DATA),
    .i_ps       (r_ps),
    .o_bit_done (w_bit_done),
    .o_bit_idx  (w_idx)
  );

  // State register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Frame configuration latched at acceptance so mid-frame input changes are ignored.
  always_ff @(posedge CLK or negedge Reset) begin
    // NOTE: the data latch is reset too; it is a handful of flops, and a known
    // value keeps the parity generator free of X before the first frame.
    if (!Reset) begin
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= PAR_EVEN;
      r_ps      <= PRESCALE_WIDTH'(1);
    end else if (w_accept) begin
      r_data    <= bus.P_DATA;
      r_par_en  <= bus.PAR_EN;
      r_par_typ <= bus.PAR_TYP;
      r_ps      <= (bus.Prescale == '0) ? PRESCALE_WIDTH'(1) : bus.Prescale;
    end
  end

  // Next-state logic: advance one frame field per completed bit.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (bus.Data_Valid) w_next = ST_START;
      ST_START:  if (w_bit_done) w_next = ST_DATA;
      ST_DATA:   if (w_bit_done && (w_idx == IDX_W'(DATA_WIDTH - 1)))
                   w_next = r_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_done) w_next = ST_STOP;
      ST_STOP:   if (w_bit_done) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output logic: the line value for the state being entered, so it is
  // registered on the same edge as the state change.
  always_comb begin
    w_out_idx = '0;
    if (r_state == ST_DATA) w_out_idx = w_bit_done ? w_idx + 1'b1 : w_idx;
    w_tx_d   = LINE_IDLE;
    w_busy_d = 1'b1;
    unique case (w_next)
      ST_IDLE:   w_busy_d = 1'b0;
      ST_START:  w_tx_d   = 1'b0;
      ST_DATA:   w_tx_d   = r_data[w_out_idx];
      ST_PARITY: w_tx_d   = w_par;
      ST_STOP:   w_tx_d   = LINE_IDLE;
      default:   w_busy_d = 1'b0;
    endcase
  end

  // Output register: no combinational path from inputs to TX_OUT or Busy.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_tx   <= LINE_IDLE;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_d;
      r_busy <= w_busy_d;
    end
  end

  assign bus.TX_OUT = r_tx;
  assign bus.Busy   = r_busy;

endmodule
